// File: rtl/mem_arbiter_pkg.sv
// Shared definitions for the I/D memory arbiter: FSM encoding, starvation
// limit default and starve-counter width helper.
package mem_arbiter_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_BUSY_I = 3'd1,
        ST_BUSY_D = 3'd2,
        ST_RESP_I = 3'd3,
        ST_RESP_D = 3'd4
    } arb_state_t;

    localparam int STARVE_LIMIT_DEFAULT = 4;

    // Width able to hold 0..limit; never narrower than one bit.
    function automatic int starve_cnt_w(input int limit);
        return (limit < 2) ? 1 : $clog2(limit + 1);
    endfunction

endpackage

// File: rtl/mem_arbiter_starve_counter.sv
// Saturating counter of consecutive D grants taken while the I side waits.
module mem_arbiter_starve_counter
    import mem_arbiter_pkg::*;
#(
    parameter int LIMIT = STARVE_LIMIT_DEFAULT,
    parameter int CNT_W = starve_cnt_w(LIMIT)
) (
    input  logic clk,
    input  logic rst,
    input  logic i_inc,
    input  logic i_clr,
    output logic o_sat
);

    localparam logic [CNT_W-1:0] LIMIT_V = CNT_W'(LIMIT);

    logic [CNT_W-1:0] r_count;
    logic             w_sat;

    assign w_sat = (r_count == LIMIT_V);
    assign o_sat = w_sat;

    // Clear wins over increment; increment stops at the limit.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_count <= '0;
        end else if (i_clr) begin
            r_count <= '0;
        end else if (i_inc && !w_sat) begin
            r_count <= r_count + CNT_W'(1);
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Two-requester (ICache refill / DCache) arbiter onto a single external memory
// port, with D priority bounded by a starvation limit and I-response cancel.
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int ADDR_W       = 32,
    parameter int DATA_W       = 32,
    parameter int STARVE_LIMIT = STARVE_LIMIT_DEFAULT
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_req,
    input  logic [ADDR_W-1:0] i_addr,
    input  logic              i_flush,
    output logic              i_ack,
    output logic [DATA_W-1:0] i_rdata,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_ack,
    output logic [DATA_W-1:0] d_rdata,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_ack,
    input  logic [DATA_W-1:0] mem_rdata
);

    arb_state_t        r_state;
    logic              r_i_ack;
    logic              r_d_ack;
    logic              r_mem_req;
    logic              r_mem_we;
    logic              r_cancel;
    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_wdata;
    logic [DATA_W-1:0] r_i_rdata;
    logic [DATA_W-1:0] r_d_rdata;

    logic w_idle;
    logic w_starved;
    logic w_grant_d;
    logic w_grant_i;
    logic w_i_cancel;

    assign w_idle     = (r_state == ST_IDLE);
    assign w_grant_d  = w_idle && d_req && !(i_req && w_starved);
    assign w_grant_i  = w_idle && i_req && !w_grant_d;
    assign w_i_cancel = r_cancel || i_flush;

    mem_arbiter_starve_counter #(
        .LIMIT (STARVE_LIMIT)
    ) u_starve (
        .clk   (clk),
        .rst   (rst),
        .i_inc (w_grant_d && i_req),
        .i_clr (w_grant_i),
        .o_sat (w_starved)
    );

    // Arbitration FSM; every output is a register updated here.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= ST_IDLE;
            r_i_ack   <= 1'b0;
            r_d_ack   <= 1'b0;
            r_mem_req <= 1'b0;
            r_mem_we  <= 1'b0;
            r_cancel  <= 1'b0;
            r_addr    <= '0;
            r_wdata   <= '0;
            r_i_rdata <= '0;
            r_d_rdata <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_cancel <= 1'b0;
                    r_i_ack  <= 1'b0;
                    r_d_ack  <= 1'b0;
                    if (w_grant_d) begin
                        r_state   <= ST_BUSY_D;
                        r_mem_req <= 1'b1;
                        r_mem_we  <= d_we;
                        r_addr    <= d_addr;
                        r_wdata   <= d_wdata;
                    end else if (w_grant_i) begin
                        r_state   <= ST_BUSY_I;
                        r_mem_req <= 1'b1;
                        r_mem_we  <= 1'b0;
                        r_addr    <= i_addr;
                        r_wdata   <= '0;
                    end else begin
                        r_mem_req <= 1'b0;
                        r_mem_we  <= 1'b0;
                    end
                end
                ST_BUSY_I: begin
                    r_cancel <= w_i_cancel;
                    if (mem_ack) begin
                        r_state   <= ST_RESP_I;
                        r_mem_req <= 1'b0;
                        r_mem_we  <= 1'b0;
                        r_i_ack   <= !w_i_cancel;
                        // A cancelled refill leaves the previous I data visible.
                        if (!w_i_cancel) begin
                            r_i_rdata <= mem_rdata;
                        end
                    end
                end
                ST_BUSY_D: begin
                    if (mem_ack) begin
                        r_state   <= ST_RESP_D;
                        r_mem_req <= 1'b0;
                        r_mem_we  <= 1'b0;
                        r_d_ack   <= 1'b1;
                        r_d_rdata <= mem_rdata;
                    end
                end
                ST_RESP_I: begin
                    r_state  <= ST_IDLE;
                    r_i_ack  <= 1'b0;
                    r_cancel <= 1'b0;
                end
                ST_RESP_D: begin
                    r_state  <= ST_IDLE;
                    r_d_ack  <= 1'b0;
                    r_cancel <= 1'b0;
                end
                default: begin
                    r_state   <= ST_IDLE;
                    r_i_ack   <= 1'b0;
                    r_d_ack   <= 1'b0;
                    r_mem_req <= 1'b0;
                    r_mem_we  <= 1'b0;
                    r_cancel  <= 1'b0;
                end
            endcase
        end
    end

    assign i_ack     = r_i_ack;
    assign d_ack     = r_d_ack;
    assign i_rdata   = r_i_rdata;
    assign d_rdata   = r_d_rdata;
    assign mem_req   = r_mem_req;
    assign mem_we    = r_mem_we;
    assign mem_addr  = r_addr;
    assign mem_wdata = r_wdata;

endmodule
